lane_change_logger: RTL

Downstream consumer of the `top` stage. It samples the bank of `changingSignal` outputs, one lane per `submodule` instance (16 lanes: `w`, `x`, `x1`..`x14`). Every cycle in which any lane changes produces a timestamped event carrying a change mask and the new lane levels. Events are buffered in a small FIFO and drained through a valid/ready port. Overflow is reported by a sticky flag and a saturating drop counter.

---
 rtl/lane_change_logger.sv | 76 +++++++
 1 files changed

// File: rtl/lane_change_logger.sv
// lane_change_logger: timestamps lane change events into a show-ahead FIFO drained by valid/ready
// Ports: clk, rst (async, active-high); lanes_i lane levels; clear_i clears overflow/drop count;
//        evt_valid_o/evt_ready_i/evt_mask_o/evt_level_o/evt_time_o event port;
//        overflow_o sticky drop flag; drop_count_o saturating drops; fifo_level_o occupancy.
module lane_change_logger #(
  parameter int N_LANES    = 16,
  parameter int TS_WIDTH   = 16,
  parameter int DEPTH      = 8,
  parameter int DROP_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_LANES-1:0]         lanes_i,
  input  logic                       clear_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [N_LANES-1:0]         evt_mask_o,
  output logic [N_LANES-1:0]         evt_level_o,
  output logic [TS_WIDTH-1:0]        evt_time_o,
  output logic                       overflow_o,
  output logic [DROP_WIDTH-1:0]      drop_count_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * N_LANES + TS_WIDTH;
  logic [EW-1:0]         r_mem [DEPTH];
  logic [TS_WIDTH-1:0]   r_ts;
  logic                  r_armed;
  logic [N_LANES-1:0]    r_prev;
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_ovf;
  logic [DROP_WIDTH-1:0] r_drop;
  logic [N_LANES-1:0]    w_chg;
  logic                  w_push, w_pop, w_full, w_wr, w_drop;
  logic [DROP_WIDTH-1:0] w_drop_base;
  logic [EW-1:0]         w_head;
  always_comb begin
    w_chg       = r_armed ? lanes_i ^ r_prev : '0;
    w_push      = |w_chg;
    w_pop       = evt_valid_o & evt_ready_i;
    w_full      = r_count == (AW+1)'(DEPTH);
    w_wr        = w_push & (~w_full | w_pop);
    w_drop      = w_push & w_full & ~w_pop;
    w_drop_base = clear_i ? '0 : r_drop;
    w_head      = evt_valid_o ? r_mem[r_rd_ptr] : '0;
  end
  assign evt_valid_o  = r_count != '0;
  assign {evt_mask_o, evt_level_o, evt_time_o} = w_head;
  assign overflow_o   = r_ovf;
  assign drop_count_o = r_drop;
  assign fifo_level_o = r_count;
  always_ff @(posedge clk) if (w_wr) r_mem[r_wr_ptr] <= {w_chg, lanes_i, r_ts};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts     <= '0;
      r_armed  <= 1'b0;
      r_prev   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
    end else begin
      r_ts     <= r_ts + TS_WIDTH'(1);
      r_armed  <= 1'b1;
      r_prev   <= lanes_i;
      r_wr_ptr <= w_wr ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_count  <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      // a drop on the same edge as clear wins over the clear
      r_ovf    <= w_drop | (r_ovf & ~clear_i);
      r_drop   <= ~w_drop ? w_drop_base : &w_drop_base ? w_drop_base : w_drop_base + DROP_WIDTH'(1);
    end
  end
endmodule
